// File: rtl/alu_result_capture.sv
// Captures ALU results into a 2-entry in-order FIFO for writeback and
// updates the {ZF, SF, OF} condition codes on accepted results.
module alu_result_capture #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DST_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_of,
    input  logic             set_cc,
    input  logic [DST_W-1:0] in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [DST_W-1:0] out_dst,
    output logic [2:0]       cc
);

    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem_val [DEPTH];
    logic [DST_W-1:0] mem_dst [DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             accept;
    logic             pop;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // FIFO control, storage, registered head view and condition codes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_val   <= '0;
            out_dst   <= '0;
            cc        <= 3'b100;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_val[i] <= '0;
                mem_dst[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_val[wr_ptr] <= alu_out;
                mem_dst[wr_ptr] <= in_dst;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && set_cc) begin
                cc <= {(alu_out == '0), alu_out[WIDTH-1], alu_of};
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_val   <= alu_out;
                        out_dst   <= in_dst;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (pop && !accept) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (accept && pop) begin
                        // Lone entry leaves while the new one arrives: new one is head
                        out_val <= alu_out;
                        out_dst <= in_dst;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                        out_val  <= mem_val[~rd_ptr];
                        out_dst  <= mem_dst[~rd_ptr];
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture: driver queues expected results,
// monitor checks each popped head entry in order.
module tb_alu_result_capture;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DST_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic             alu_of;
    logic             set_cc;
    logic [DST_W-1:0] in_dst;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_val;
    logic [DST_W-1:0] out_dst;
    logic [2:0]       cc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic [DST_W-1:0] dst;
    } entry_t;

    entry_t exp_q[$];

    alu_result_capture #(.WIDTH(WIDTH), .DST_W(DST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .alu_of    (alu_of),
        .set_cc    (set_cc),
        .in_dst    (in_dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .out_dst   (out_dst),
        .cc        (cc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop must match the oldest outstanding expected entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h/%0h expected none", out_val, out_dst);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("pop_val", out_val, e.val);
                check("pop_dst", 64'(out_dst), 64'(e.dst));
            end
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge
    task automatic step(input logic v, input logic [WIDTH-1:0] val, input logic [DST_W-1:0] d,
                        input logic sc, input logic of, input logic ordy);
        in_valid  = v;
        alu_out   = val;
        in_dst    = d;
        set_cc    = sc;
        alu_of    = of;
        out_ready = ordy;
        @(negedge clk);
        if (v && in_ready && !rst) exp_q.push_back({val, d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; alu_out = '0; alu_of = 1'b0; set_cc = 1'b0; in_dst = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_cc", 64'(cc), 64'h4);
        check("rst_out_val", out_val, 64'd0);
        check("rst_out_dst", 64'(out_dst), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check("idle_out_valid", 64'(out_valid), 64'd0);
            check("idle_cc", 64'(cc), 64'h4);
        end

        // Single pass-through
        step(1'b1, 64'h5555555555555555, 4'd3, 1'b1, 1'b0, 1'b1);
        check("pt_out_valid", 64'(out_valid), 64'd1);
        check("pt_out_val", out_val, 64'h5555555555555555);
        check("pt_cc", 64'(cc), 64'h0);
        idle(1'b1);
        check("pt_drained", 64'(out_valid), 64'd0);

        // Fill and stall
        step(1'b1, 64'h1, 4'd1, 1'b0, 1'b0, 1'b0);
        check("fill1_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 64'h2, 4'd2, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head", out_val, 64'h1);
        step(1'b1, 64'h3, 4'd3, 1'b0, 1'b0, 1'b0);
        check("full_hold_head", out_val, 64'h1);
        check("full_hold_dst", 64'(out_dst), 64'd1);
        idle(1'b1);
        check("pop1_in_ready", 64'(in_ready), 64'd1);
        check("pop1_head", out_val, 64'h2);
        idle(1'b1);
        check("pop2_out_valid", 64'(out_valid), 64'd0);

        // Simultaneous accept and pop while holding one entry
        step(1'b1, 64'hA, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 4'd6, 1'b0, 1'b0, 1'b1);
        check("sim_out_valid", 64'(out_valid), 64'd1);
        check("sim_in_ready", 64'(in_ready), 64'd1);
        check("sim_head", out_val, 64'hB);
        check("sim_dst", 64'(out_dst), 64'd6);
        idle(1'b1);
        check("sim_drained", 64'(out_valid), 64'd0);

        // Condition codes
        step(1'b1, 64'h0, 4'd1, 1'b1, 1'b0, 1'b1);
        check("cc_zero", 64'(cc), 64'h4);
        step(1'b1, 64'h8000000000000000, 4'd2, 1'b1, 1'b1, 1'b1);
        check("cc_neg_of", 64'(cc), 64'h3);
        step(1'b1, 64'h7, 4'd3, 1'b0, 1'b0, 1'b1);
        check("cc_no_set", 64'(cc), 64'h3);
        idle(1'b1);
        check("cc_drained", 64'(out_valid), 64'd0);

        // Fill, then offer a set_cc result while FULL
        step(1'b1, 64'h10, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h20, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h0, 4'd3, 1'b1, 1'b0, 1'b0);
        check("full_cc_hold", 64'(cc), 64'h3);
        check("full2_in_ready", 64'(in_ready), 64'd0);
        check("full2_head", out_val, 64'h10);

        // Reset wins over simultaneous accept and pop
        rst = 1'b1;
        step(1'b1, 64'h99, 4'd9, 1'b1, 1'b1, 1'b1);
        exp_q.delete();
        rst = 1'b0;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        check("mrst_cc", 64'(cc), 64'h4);
        check("mrst_out_val", out_val, 64'd0);
        idle(1'b1);
        check("mrst_idle_valid", 64'(out_valid), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
